// File: rtl/frequency_counter_pkg.sv
// Shared types for the frequency counter: FSM state encoding.
package frequency_counter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/synchronizer_2ff.sv
// Two-flop synchronizer for bringing asynchronous signals into the clock domain.
module synchronizer_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/frequency_counter.sv
// Counts rising edges of signal_in over a fixed gate of WINDOW_CYCLES clocks.
// Define FREQUENCY_COUNTER_CONTINUOUS_EN for back-to-back windows after the first start.
module frequency_counter
    import frequency_counter_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16,
    parameter int WINDOW_CYCLES = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     signal_in,
    input  logic                     start,
    output logic                     busy,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     count_valid,
    output logic                     overflow
);

    localparam int                     WIN_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0]         WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] ACC_MAX  = '1;

    state_t                     state, next_state;
    logic                       sig_sync, sig_prev, edge_flag;
    logic [WIN_W-1:0]           win_cnt;
    logic [COUNTER_WIDTH-1:0]   acc, acc_next;
    logic                       sat, sat_next;
    logic                       window_end, window_load;

    synchronizer_2ff #(.WIDTH(1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (signal_in),
        .q     (sig_sync)
    );

    always_ff @(posedge clock) begin
        if (reset) sig_prev <= 1'b0;
        else       sig_prev <= sig_sync;
    end

    assign edge_flag   = sig_sync & ~sig_prev;
    assign window_end  = (state == MEASURE) && (win_cnt == WIN_LAST);
    assign window_load = (next_state == MEASURE) && (state != MEASURE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: default assigned first so no path through the block leaves next_state unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = MEASURE;
            MEASURE: if (window_end) next_state = DONE;
            DONE: begin
`ifdef FREQUENCY_COUNTER_CONTINUOUS_EN
                next_state = MEASURE;
`else
                next_state = start ? MEASURE : IDLE;
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    // The final cycle's flag must land in count, so the result is taken from the next-value terms.
    assign acc_next = (edge_flag && (acc != ACC_MAX)) ? acc + 1'b1 : acc;
    assign sat_next = sat | (edge_flag & (acc == ACC_MAX));

    always_ff @(posedge clock) begin
        if (reset) begin
            win_cnt  <= '0;
            acc      <= '0;
            sat      <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (window_load) begin
                win_cnt <= '0;
                acc     <= '0;
                sat     <= 1'b0;
            end else if (state == MEASURE) begin
                win_cnt <= win_cnt + 1'b1;
                acc     <= acc_next;
                sat     <= sat_next;
            end
            if (window_end) begin
                count    <= acc_next;
                overflow <= sat_next;
            end
        end
    end

    assign busy        = (state == MEASURE);
    assign count_valid = (state == DONE);

endmodule
